pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed-width flush-only pipeline registers between stages.
- Carries a generic control/data bundle plus the instruction word through one stage, using a valid/ready handshake.
- Includes a 1-entry skid buffer, so backpressure is absorbed without a combinational ready path.
- Supports flush-to-NOP and saturating stall/flush statistics counters. Instantiated between decode/execute and execute/memory.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_elastic.sv | 122 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stages: occupancy encoding, default NOP,
// and the packed bundles carried between decode/execute and execute/memory.
package pipe_pkg;

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable by construction.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  rd;
  } dec_ex_t;

  typedef struct packed {
    logic [15:0] alu_res;
    logic [15:0] store_data;
    logic [2:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        wb_en;
  } ex_mem_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, with a synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// One elastic pipeline stage: main register plus a 1-entry skid buffer so that
// in_ready comes straight from a flop, with flush-to-NOP and stall/flush counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = $bits(dec_ex_t),
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  stage_state_t       state, state_next;
  logic               in_ready_q;
  logic [DATA_W-1:0]  main_data, skid_data;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic               main_valid, skid_valid, in_fire;
  logic               load_main_in, load_main_skid, load_skid;

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_SKID);
  assign in_ready   = in_ready_q;
  assign in_fire    = in_valid && in_ready_q;

  // The skid only fills when main is stuck, so a SKID drain never takes new input.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_next   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (in_fire) load_main_in = 1'b1;
          else         state_next   = ST_EMPTY;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = ST_SKID;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_next     = ST_FULL;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_instr <= NOP_INSTR;
      skid_data  <= '0;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_instr <= NOP_INSTR;
      skid_data  <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_SKID);
      if (load_main_in) begin
        main_data  <= in_data;
        main_instr <= in_instr;
      end else if (load_main_skid) begin
        main_data  <= skid_data;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_data  <= in_data;
        skid_instr <= in_instr;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_instr = main_valid ? main_instr : NOP_INSTR;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (main_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (flush && (main_valid || skid_valid || in_fire)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a queue scoreboard follows every handshake while
// scenario tasks check the directed expectations for each feature.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int DATA_W  = $bits(dec_ex_t);
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  logic               clk, reset, flush, in_valid, out_ready;
  logic [DATA_W-1:0]  in_data;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready, out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  logic               in_ready_s, out_valid_s;
  logic [DATA_W-1:0]  out_data_s;
  logic [INSTR_W-1:0] out_instr_s;
  logic [3:0]         stall_cnt_s, flush_cnt_s;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  beat_t              sb[$];
  logic [DATA_W-1:0]  last_data;
  logic [CNT_W-1:0]   exp_stall, exp_flush;
  logic               m_held, m_in_fire, m_out_fire;
  logic               exp_valid, exp_ready;
  logic [INSTR_W-1:0] exp_instr;
  logic [DATA_W-1:0]  exp_data;
  int                 total = 0;
  int                 bad = 0;

  pipe_stage_elastic #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_instr(out_instr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_elastic #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_instr(in_instr), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_instr(out_instr_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of at most two beats advanced on every active edge.
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      last_data = '0;
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      m_held     = (sb.size() > 0);
      m_in_fire  = in_valid && (sb.size() < 2);
      m_out_fire = m_held && out_ready;
      if (m_held && !out_ready) exp_stall = exp_stall + 1'b1;
      if (m_out_fire) begin
        last_data = sb[0].data;
        void'(sb.pop_front());
      end
      if (flush) begin
        if (m_held || m_in_fire) exp_flush = exp_flush + 1'b1;
        sb.delete();
        last_data = '0;
      end else if (m_in_fire) begin
        sb.push_back({in_data, in_instr});
      end
    end
  end

  // Scoreboard comparison mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last_data = '0;
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      exp_valid = (sb.size() > 0);
      exp_ready = (sb.size() < 2);
      exp_instr = exp_valid ? sb[0].instr : NOP;
      exp_data  = exp_valid ? sb[0].data : last_data;
      total += 6;
      if (out_valid !== exp_valid) begin bad++; $display("[TB] FAIL sb_out_valid: got %0b want %0b", out_valid, exp_valid); end
      if (in_ready !== exp_ready) begin bad++; $display("[TB] FAIL sb_in_ready: got %0b want %0b", in_ready, exp_ready); end
      if (out_instr !== exp_instr) begin bad++; $display("[TB] FAIL sb_out_instr: got %h want %h", out_instr, exp_instr); end
      if (out_data !== exp_data) begin bad++; $display("[TB] FAIL sb_out_data: got %h want %h", out_data, exp_data); end
      if (stall_cnt !== exp_stall) begin bad++; $display("[TB] FAIL sb_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
      if (flush_cnt !== exp_flush) begin bad++; $display("[TB] FAIL sb_flush_cnt: got %0d want %0d", flush_cnt, exp_flush); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [INSTR_W-1:0] instr, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_data   = DATA_W'({$urandom(), $urandom()});
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    tick();
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (out_instr !== NOP) begin bad++; $display("[TB] FAIL reset_out_instr: got %h want %h", out_instr, NOP); end
    if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    if (stall_cnt !== '0) begin bad++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    if (flush_cnt !== '0) begin bad++; $display("[TB] FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    do_reset();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'(16'h1111 + i), 1'b1, 1'b0);
      tick();
      total += 2;
      if (out_instr !== 16'(16'h1111 + i)) begin bad++; $display("[TB] FAIL stream_latency: got %h want %h", out_instr, 16'(16'h1111 + i)); end
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_in_ready: got %0b want 1", in_ready); end
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (2) tick();
    total += 2;
    if (stall_cnt !== '0) begin bad++; $display("[TB] FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    if (out_instr !== NOP) begin bad++; $display("[TB] FAIL stream_idle_nop: got %h want %h", out_instr, NOP); end
  endtask

  task automatic test_backpressure();
    do_reset();
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    tick();
    total += 2;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_skid_in_ready: got %0b want 0", in_ready); end
    if (out_instr !== 16'h2222) begin bad++; $display("[TB] FAIL bp_head_held: got %h want 2222", out_instr); end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) tick();
    out_ready = 1'b1;
    tick();
    total += 2;
    if (out_instr !== 16'h3333) begin bad++; $display("[TB] FAIL bp_second_beat: got %h want 3333", out_instr); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back: got %0b want 1", in_ready); end
    tick();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %0b want 0", out_valid); end
    if (stall_cnt !== 16'd3) begin bad++; $display("[TB] FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush_skid();
    do_reset();
    applyStimulus(1'b1, 16'hA001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hA002, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hBAD0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_skid_valid: got %0b want 0", out_valid); end
    if (out_instr !== NOP) begin bad++; $display("[TB] FAIL flush_skid_instr: got %h want %h", out_instr, NOP); end
    if (out_data !== '0) begin bad++; $display("[TB] FAIL flush_skid_data: got %h want 0", out_data); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_skid_ready: got %0b want 1", in_ready); end
    if (flush_cnt !== 16'd1) begin bad++; $display("[TB] FAIL flush_skid_cnt: got %0d want 1", flush_cnt); end
    repeat (3) tick();
    total += 1;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_skid_ghost: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    tick();
    total += 3;
    if (flush_cnt !== '0) begin bad++; $display("[TB] FAIL flush_empty_cnt: got %0d want 0", flush_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty_ready: got %0b want 1", in_ready); end
    applyStimulus(1'b1, 16'hC001, 1'b1, 1'b1);
    tick();
    total += 2;
    if (flush_cnt !== 16'd1) begin bad++; $display("[TB] FAIL flush_incoming_cnt: got %0d want 1", flush_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_incoming_valid: got %0b want 0", out_valid); end
    applyStimulus(1'b1, 16'hC002, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hC003, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    total += 2;
    if (flush_cnt !== 16'd2) begin bad++; $display("[TB] FAIL flush_full_cnt: got %0d want 2", flush_cnt); end
    if (out_instr !== NOP) begin bad++; $display("[TB] FAIL flush_full_instr: got %h want %h", out_instr, NOP); end
  endtask

  task automatic test_saturation();
    do_reset();
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (16) tick();
    total += 1;
    if (stall_cnt_s !== 4'd15) begin bad++; $display("[TB] FAIL sat_reached: got %0d want 15", stall_cnt_s); end
    repeat (4) tick();
    total += 2;
    if (stall_cnt_s !== 4'd15) begin bad++; $display("[TB] FAIL sat_held: got %0d want 15", stall_cnt_s); end
    if (stall_cnt !== 16'd20) begin bad++; $display("[TB] FAIL sat_wide_cnt: got %0d want 20", stall_cnt); end
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    applyStimulus(1'b1, 16'h6666, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_ready: got %0b want 1", in_ready); end
    if (out_instr !== NOP) begin bad++; $display("[TB] FAIL async_instr: got %h want %h", out_instr, NOP); end
    if (out_data !== '0) begin bad++; $display("[TB] FAIL async_data: got %h want 0", out_data); end
    if (stall_cnt !== '0) begin bad++; $display("[TB] FAIL async_stall: got %0d want 0", stall_cnt); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL async_first_valid: got %0b want 1", out_valid); end
    if (out_instr !== 16'h4444) begin bad++; $display("[TB] FAIL async_first_instr: got %h want 4444", out_instr); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'(16'h8000 + i), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 19) == 0);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (4) tick();
    total += 1;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained: got %0b want 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_flush_empty();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
